// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage: either a two-entry skid buffer with registered in_ready,
// or a single register with combinational in_ready. Counts entries discarded by flush.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [15:0]       flush_drops
);

  logic [DATA_W-1:0] m_data_p0;
  logic              m_vld_p0;
  logic              s_vld_p1;
  logic              in_fire;
  logic              out_fire;
  logic [1:0]        drops;

  function automatic logic [15:0] sat_add16(input logic [15:0] acc, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, acc} + {15'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_valid = m_vld_p0;
  assign out_data  = m_vld_p0 ? m_data_p0 : '0;
  assign occupancy = {1'b0, m_vld_p0} + {1'b0, s_vld_p1};
  // An entry handed downstream in the flush cycle is delivered, not dropped.
  assign drops     = {1'b0, m_vld_p0 & ~out_fire} + {1'b0, s_vld_p1};

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] s_data_p1;
      logic              s_vld_q;

      assign in_ready = ~s_vld_q & ~flush;
      assign s_vld_p1 = s_vld_q;

      // Stage p0 is the presented slot; p1 is the skid slot behind it.
      always_ff @(posedge clk) begin
        if (reset) begin
          m_vld_p0  <= 1'b0;
          s_vld_q   <= 1'b0;
          m_data_p0 <= '0;
          s_data_p1 <= '0;
        end else if (flush) begin
          m_vld_p0 <= 1'b0;
          s_vld_q  <= 1'b0;
        end else if (!m_vld_p0) begin
          if (in_fire) begin
            m_vld_p0  <= 1'b1;
            m_data_p0 <= in_data;
          end
        end else if (out_fire) begin
          if (s_vld_q) begin
            m_data_p0 <= s_data_p1;
            s_vld_q   <= 1'b0;
          end else if (in_fire) begin
            m_data_p0 <= in_data;
          end else begin
            m_vld_p0 <= 1'b0;
          end
        end else if (in_fire) begin
          s_vld_q   <= 1'b1;
          s_data_p1 <= in_data;
        end
      end
    end else begin : g_single
      assign in_ready = (~m_vld_p0 | out_ready) & ~flush;
      assign s_vld_p1 = 1'b0;

      // Stage p0 only: the presented slot, refilled in the same cycle it drains.
      always_ff @(posedge clk) begin
        if (reset) begin
          m_vld_p0  <= 1'b0;
          m_data_p0 <= '0;
        end else if (flush) begin
          m_vld_p0 <= 1'b0;
        end else if (in_fire) begin
          m_vld_p0  <= 1'b1;
          m_data_p0 <= in_data;
        end else if (out_fire) begin
          m_vld_p0 <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      flush_drops <= '0;
    end else if (flush) begin
      flush_drops <= sat_add16(flush_drops, drops);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, corner sequences, and randomized
// traffic on SKID=1 and SKID=0 instances checked against a FIFO-level model.
module tb_pipe_stage_reg;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush, in_valid, out_ready, in_ready, out_valid;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;
  logic [15:0]   flush_drops;
  logic          flush_z, in_valid_z, out_ready_z, in_ready_z, out_valid_z;
  logic [DW-1:0] in_data_z, out_data_z;
  logic [1:0]    occupancy_z;
  logic [15:0]   flush_drops_z;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .SKID(1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .flush_drops(flush_drops)
  );

  pipe_stage_reg #(.DATA_W(DW), .SKID(0)) dut_z (
    .clk(clk), .reset(reset), .flush(flush_z), .in_valid(in_valid_z), .in_ready(in_ready_z),
    .in_data(in_data_z), .out_valid(out_valid_z), .out_ready(out_ready_z), .out_data(out_data_z),
    .occupancy(occupancy_z), .flush_drops(flush_drops_z)
  );

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        orr;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    logic [1:0]  e_occ;
    logic [15:0] e_fd;
  } vec_t;

  vec_t vecs[21];

  // Reference model: index 1 = skid stage (capacity 2), index 0 = single register (capacity 1).
  logic [31:0] mf[2][2];
  int          mcnt[2];
  int          mdrop[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set1(input logic fl, input logic iv, input logic [31:0] d, input logic orr);
    flush = fl; in_valid = iv; in_data = d; out_ready = orr;
  endtask

  task automatic set0(input logic fl, input logic iv, input logic [31:0] d, input logic orr);
    flush_z = fl; in_valid_z = iv; in_data_z = d; out_ready_z = orr;
  endtask

  task automatic chk1(input string tag, input logic ov, input logic [31:0] od,
                      input logic [1:0] occ, input logic [15:0] fd);
    check({tag, "_ov"}, 64'(out_valid), 64'(ov));
    check({tag, "_od"}, 64'(out_data), 64'(od));
    check({tag, "_occ"}, 64'(occupancy), 64'(occ));
    check({tag, "_fd"}, 64'(flush_drops), 64'(fd));
  endtask

  task automatic chk0(input string tag, input logic ov, input logic [31:0] od,
                      input logic [1:0] occ, input logic [15:0] fd);
    check({tag, "_ov"}, 64'(out_valid_z), 64'(ov));
    check({tag, "_od"}, 64'(out_data_z), 64'(od));
    check({tag, "_occ"}, 64'(occupancy_z), 64'(occ));
    check({tag, "_fd"}, 64'(flush_drops_z), 64'(fd));
  endtask

  function automatic logic m_ready(input int k, input logic fl, input logic orr);
    if (fl) return 1'b0;
    if (k == 1) return mcnt[1] < 2;
    return (mcnt[0] == 0) || orr;
  endfunction

  task automatic m_edge(input int k, input logic fl, input logic iv, input logic orr,
                        input logic [31:0] d);
    logic ofire, ifire;
    ofire = (mcnt[k] > 0) && orr;
    ifire = iv && m_ready(k, fl, orr);
    if (fl) begin
      mdrop[k] = mdrop[k] + mcnt[k] - (ofire ? 1 : 0);
      if (mdrop[k] > 65535) mdrop[k] = 65535;
      mcnt[k] = 0;
    end else begin
      if (ofire) begin
        mf[k][0] = mf[k][1];
        mcnt[k]--;
      end
      if (ifire) begin
        mf[k][mcnt[k]] = d;
        mcnt[k]++;
      end
    end
  endtask

  task automatic m_check(input int k);
    logic [31:0] eod;
    eod = (mcnt[k] > 0) ? mf[k][0] : 32'd0;
    if (k == 1) chk1("rnd1", mcnt[1] > 0, eod, 2'(mcnt[1]), 16'(mdrop[1]));
    else        chk0("rnd0", mcnt[0] > 0, eod, 2'(mcnt[0]), 16'(mdrop[0]));
  endtask

  initial begin
    logic        rfl1, riv1, ror1, rfl0, riv0, ror0;
    logic [31:0] rd1, rd0;

    //            fl    iv    data        or    | ir    ov    od          occ   fd
    vecs[0]  = '{1'b0, 1'b1, 32'h11,     1'b1,   1'b1, 1'b1, 32'h11,     2'd1, 16'd0};
    vecs[1]  = '{1'b0, 1'b1, 32'h22,     1'b1,   1'b1, 1'b1, 32'h22,     2'd1, 16'd0};
    vecs[2]  = '{1'b0, 1'b1, 32'h33,     1'b1,   1'b1, 1'b1, 32'h33,     2'd1, 16'd0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,      1'b1,   1'b1, 1'b0, 32'h0,      2'd0, 16'd0};
    vecs[4]  = '{1'b0, 1'b1, 32'hA,      1'b0,   1'b1, 1'b1, 32'hA,      2'd1, 16'd0};
    vecs[5]  = '{1'b0, 1'b1, 32'hB,      1'b0,   1'b1, 1'b1, 32'hA,      2'd2, 16'd0};
    vecs[6]  = '{1'b0, 1'b1, 32'hC,      1'b0,   1'b0, 1'b1, 32'hA,      2'd2, 16'd0};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,      1'b1,   1'b0, 1'b1, 32'hB,      2'd1, 16'd0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,      1'b1,   1'b1, 1'b0, 32'h0,      2'd0, 16'd0};
    vecs[9]  = '{1'b0, 1'b1, 32'hD,      1'b0,   1'b1, 1'b1, 32'hD,      2'd1, 16'd0};
    vecs[10] = '{1'b0, 1'b1, 32'hE,      1'b0,   1'b1, 1'b1, 32'hD,      2'd2, 16'd0};
    vecs[11] = '{1'b1, 1'b1, 32'hF,      1'b0,   1'b0, 1'b0, 32'h0,      2'd0, 16'd2};
    vecs[12] = '{1'b0, 1'b1, 32'h55,     1'b0,   1'b1, 1'b1, 32'h55,     2'd1, 16'd2};
    vecs[13] = '{1'b1, 1'b0, 32'h0,      1'b1,   1'b0, 1'b0, 32'h0,      2'd0, 16'd2};
    vecs[14] = '{1'b0, 1'b1, 32'h66,     1'b0,   1'b1, 1'b1, 32'h66,     2'd1, 16'd2};
    vecs[15] = '{1'b1, 1'b0, 32'h0,      1'b0,   1'b0, 1'b0, 32'h0,      2'd0, 16'd3};
    vecs[16] = '{1'b1, 1'b0, 32'h0,      1'b0,   1'b0, 1'b0, 32'h0,      2'd0, 16'd3};
    vecs[17] = '{1'b0, 1'b1, 32'h77,     1'b0,   1'b1, 1'b1, 32'h77,     2'd1, 16'd3};
    vecs[18] = '{1'b0, 1'b1, 32'h78,     1'b0,   1'b1, 1'b1, 32'h77,     2'd2, 16'd3};
    vecs[19] = '{1'b1, 1'b1, 32'h79,     1'b1,   1'b0, 1'b0, 32'h0,      2'd0, 16'd4};
    vecs[20] = '{1'b0, 1'b1, 32'hCAFE77, 1'b0,   1'b1, 1'b1, 32'hCAFE77, 2'd1, 16'd4};

    set1(1'b0, 1'b0, 32'd0, 1'b0);
    set0(1'b0, 1'b0, 32'd0, 1'b0);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk1("reset1", 1'b0, 32'd0, 2'd0, 16'd0);
    check("reset1_ir", 64'(in_ready), 64'(1));
    chk0("reset0", 1'b0, 32'd0, 2'd0, 16'd0);
    check("reset0_ir", 64'(in_ready_z), 64'(1));

    for (int i = 0; i < 21; i++) begin
      set1(vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].orr);
      #1;
      check($sformatf("vec%0d_ir", i), 64'(in_ready), 64'(vecs[i].e_ir));
      tick();
      chk1($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_od, vecs[i].e_occ, vecs[i].e_fd);
    end

    // Saturation: preload the counter just below the ceiling, then flush a full stage twice.
    force dut.flush_drops = 16'hFFFE;
    #1;
    release dut.flush_drops;
    set1(1'b0, 1'b1, 32'h88, 1'b0);
    tick();
    set1(1'b1, 1'b0, 32'd0, 1'b0);
    tick();
    chk1("sat1", 1'b0, 32'd0, 2'd0, 16'hFFFF);
    set1(1'b0, 1'b1, 32'h91, 1'b0);
    tick();
    set1(1'b0, 1'b1, 32'h92, 1'b0);
    tick();
    set1(1'b1, 1'b0, 32'd0, 1'b0);
    tick();
    chk1("sat2", 1'b0, 32'd0, 2'd0, 16'hFFFF);

    // Reset with a full stage (and flush also high) discards without counting.
    set1(1'b0, 1'b1, 32'hA1, 1'b0);
    tick();
    set1(1'b0, 1'b1, 32'hA2, 1'b0);
    tick();
    set1(1'b1, 1'b1, 32'hA3, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set1(1'b0, 1'b0, 32'd0, 1'b0);
    #1;
    chk1("rstmid", 1'b0, 32'd0, 2'd0, 16'd0);
    check("rstmid_ir", 64'(in_ready), 64'(1));

    // Single-register stall and same-cycle replace.
    set0(1'b0, 1'b1, 32'h21, 1'b0);
    #1 check("z_a_ir", 64'(in_ready_z), 64'(1));
    tick();
    chk0("z_a", 1'b1, 32'h21, 2'd1, 16'd0);
    set0(1'b0, 1'b1, 32'h22, 1'b0);
    #1 check("z_b_ir", 64'(in_ready_z), 64'(0));
    tick();
    chk0("z_b", 1'b1, 32'h21, 2'd1, 16'd0);
    set0(1'b0, 1'b1, 32'h23, 1'b1);
    #1 check("z_c_ir", 64'(in_ready_z), 64'(1));
    tick();
    chk0("z_c", 1'b1, 32'h23, 2'd1, 16'd0);
    set0(1'b0, 1'b0, 32'd0, 1'b1);
    tick();
    chk0("z_d", 1'b0, 32'd0, 2'd0, 16'd0);
    set0(1'b0, 1'b1, 32'h24, 1'b0);
    tick();
    set0(1'b1, 1'b0, 32'd0, 1'b0);
    #1 check("z_e_ir", 64'(in_ready_z), 64'(0));
    tick();
    chk0("z_e", 1'b0, 32'd0, 2'd0, 16'd1);
    set0(1'b0, 1'b1, 32'h25, 1'b0);
    tick();
    set0(1'b1, 1'b0, 32'd0, 1'b1);
    tick();
    chk0("z_f", 1'b0, 32'd0, 2'd0, 16'd1);

    // Randomized traffic against the FIFO-level model.
    set1(1'b0, 1'b0, 32'd0, 1'b0);
    set0(1'b0, 1'b0, 32'd0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0;
      mdrop[k] = 0;
      mf[k][0] = '0;
      mf[k][1] = '0;
    end
    for (int i = 0; i < 1500; i++) begin
      rfl1 = ($urandom_range(0, 15) == 0);
      riv1 = ($urandom_range(0, 9) < 6);
      ror1 = ($urandom_range(0, 9) < 5);
      rd1  = $urandom();
      rfl0 = ($urandom_range(0, 15) == 0);
      riv0 = ($urandom_range(0, 9) < 6);
      ror0 = ($urandom_range(0, 9) < 5);
      rd0  = $urandom();
      set1(rfl1, riv1, rd1, ror1);
      set0(rfl0, riv0, rd0, ror0);
      #1;
      check("rnd1_ir", 64'(in_ready), 64'(m_ready(1, rfl1, ror1)));
      check("rnd0_ir", 64'(in_ready_z), 64'(m_ready(0, rfl0, ror0)));
      tick();
      m_edge(1, rfl1, riv1, ror1, rd1);
      m_edge(0, rfl0, riv0, ror0, rd0);
      m_check(1);
      m_check(0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, payload width in bits (1..512).
REQ-002 SHALL provide parameter SKID, default 1; 1 = two-entry skid buffer with registered in_ready, 0 = single register with combinational in_ready.
REQ-003 SHALL provide port clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port flush  input  1  discards all held entries at the next edge.
REQ-006 SHALL provide port in_valid  input  1  upstream entry offered.
REQ-007 SHALL provide port in_ready  output  1  stage accepts the offered entry this cycle.
REQ-008 SHALL provide port in_data  input  DATA_W  upstream payload.
REQ-009 SHALL provide port out_valid  output  1  main entry presented downstream.
REQ-010 SHALL provide port out_ready  input  1  downstream accepts the entry this cycle.
REQ-011 SHALL provide port out_data  output  DATA_W  presented payload.
REQ-012 SHALL provide port occupancy  output  2  number of valid entries held (0..2).
REQ-013 SHALL provide port flush_drops  output  16  count of valid entries discarded by flush.

Function
REQ-014 SHALL hold a main slot M (data, valid) and, when SKID=1, a skid slot S (data, valid); SKID=0 SHALL NOT instantiate S.
REQ-015 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-016 SHALL drive out_valid = M.valid and out_data = M.data when M.valid is 1, else all zeros (bubble).
REQ-017 SHALL, for SKID=1, drive in_ready = !S.valid & !flush.
REQ-018 SHALL, for SKID=0, drive in_ready = (!M.valid | out_ready) & !flush.
REQ-019 SHALL, for SKID=1 and no flush, apply next-state rules: M empty & in_fire -> M<=in; M full & out_fire & S empty & in_fire -> M<=in; M full & !out_fire & in_fire -> S<=in; M full & out_fire & S full -> M<=S, S cleared; M full & out_fire & S empty & !in_fire -> M cleared; otherwise hold.
REQ-020 SHALL, for SKID=0 and no flush: in_fire -> M<=in; out_fire & !in_fire -> M cleared; otherwise hold.
REQ-021 SHALL give latency of exactly one cycle from in_fire to out_valid when M is empty or drains that cycle.
REQ-022 SHALL never drop, duplicate or reorder entries absent flush; payload order SHALL be FIFO through S and M.
REQ-023 SHALL, on flush, clear M.valid and S.valid at the next edge regardless of in_valid, out_ready or out_fire; any out_fire in the flush cycle still counts as delivered downstream.
REQ-024 SHALL increment flush_drops on flush by the number of valid entries not delivered that cycle (M.valid & !out_fire, plus S.valid), saturating at 0xFFFF.
REQ-025 SHALL drive occupancy = M.valid + S.valid as a registered-state function (max 1 when SKID=0).
REQ-026 SHALL leave data registers unchanged on cycles that do not load them.

Reset
REQ-027 SHALL, on reset, clear M.valid, S.valid, M.data, S.data and flush_drops to 0 at the next edge; reset SHALL take priority over flush and all transfers.
REQ-028 SHALL present after reset: out_valid=0, out_data=0, occupancy=0, flush_drops=0, in_ready=1 (flush low).
REQ-029 SHALL, on reset asserted mid-transfer, discard all held entries without incrementing flush_drops.

Verification
REQ-030 SHALL verify pass-through: SKID=1, in_valid=1 with in_data=0x11,0x22,0x33, out_ready=1 -> out_data 0x11,0x22,0x33 one cycle later each, occupancy stays 1.
REQ-031 SHALL verify skid fill: SKID=1, out_ready=0, push 0xA then 0xB -> occupancy 2, in_ready=0; raise out_ready -> 0xA then 0xB delivered in order, in_ready=1 one cycle after first pop.
REQ-032 SHALL verify flush: occupancy 2, flush=1 and out_ready=0 for one cycle -> out_valid=0, out_data=0, occupancy 0, flush_drops=2 next cycle.
REQ-033 SHALL verify flush saturation: flush_drops preloaded to 0xFFFF by repeated flushes -> further flush of occupied stage leaves 0xFFFF.
REQ-034 SHALL verify SKID=0 stall: M full, out_ready=0 -> in_ready=0, M holds; out_ready=1 with in_valid=1 -> in_ready=1 same cycle, new entry replaces M.
REQ-035 SHALL verify reset mid-operation: occupancy 2, reset=1 one cycle -> all outputs at REQ-028 values, flush_drops unchanged at 0.
